regfile_mp: RTL and testbench

- Parametrised multi-port general-purpose register file for the next-generation core.
- Provides NUM_RD combinational read ports and two write ports with same-cycle write-through bypass.
- Holds a per-register pending scoreboard for hazard detection.
- After reset, runs a hardware clear sweep so that every register reads zero.
- Sits between decode (read/scoreboard) and writeback (two retire lanes).

---
 rtl/regfile_mp_pkg.sv | 14 +
 rtl/regfile_rd_port.sv | 40 ++++
 rtl/regfile_mp.sv | 115 +++++++++++
 tb/tb_regfile_mp.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared reset polarity, default geometry and sweep FSM states
// for the multi-port register file.
package regfile_mp_pkg;

    localparam logic RstEnable = 1'b1;
    localparam int   DefDataW  = 32;
    localparam int   DefAddrW  = 5;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port with write-through bypass
// (lane 1 over lane 0) and busy masking for a same-cycle write.
module regfile_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DefDataW,
    parameter int ADDR_W   = DefAddrW,
    parameter int ZERO_REG = 1
) (
    input  logic              ready,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              pend,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    logic hit0;
    logic hit1;
    logic zero_hit;

    always_comb begin
        hit0     = we0 && (waddr0 == raddr);
        hit1     = we1 && (waddr1 == raddr);
        zero_hit = (ZERO_REG != 0) && (raddr == '0);
        rdata    = (!ready || !re || zero_hit) ? '0 :
                   hit1 ? wdata1 :
                   hit0 ? wdata0 : reg_data;
        // a write landing this cycle retires the producer, so busy drops with the bypass
        busy     = !ready || (pend && !(hit0 || hit1));
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write lanes, pending scoreboard
// and a post-reset clear sweep that zeroes every entry before use.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DefDataW,
    parameter int ADDR_W   = DefAddrW,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     init_done,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        busy,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr
);

    localparam int NREGS = 2 ** ADDR_W;

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  pend_q, pend_d;
    logic              ready;
    logic              wr0_ok;
    logic              wr1_ok;
    logic              sb_ok;

    assign ready     = (state_q == READY);
    assign init_done = ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        pend_d  = pend_q;
        wr0_ok  = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
        wr1_ok  = we1 && !((ZERO_REG != 0) && (waddr1 == '0));
        sb_ok   = sb_set && !((ZERO_REG != 0) && (sb_addr == '0));
        if (state_q == INIT) begin
            regs_d[cnt_q] = '0;
            pend_d[cnt_q] = 1'b0;
            cnt_d         = cnt_q + ADDR_W'(1);
            state_d       = (cnt_q == '1) ? READY : INIT;
        end else begin
            // lane 1 is younger, so it is applied last and wins an address clash
            if (wr0_ok) begin
                regs_d[waddr0] = wdata0;
                pend_d[waddr0] = 1'b0;
            end
            if (wr1_ok) begin
                regs_d[waddr1] = wdata1;
                pend_d[waddr1] = 1'b0;
            end
            // a new producer issued this cycle outranks the retiring one
            if (sb_ok)
                pend_d[sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // contents are only meaningful after the sweep, so the array needs no reset
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
        pend_q <= pend_d;
    end

    genvar i;
    generate
        for (i = 0; i < NUM_RD; i++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            assign ra = raddr[i*ADDR_W +: ADDR_W];
            regfile_rd_port #(
                .DATA_W  (DATA_W),
                .ADDR_W  (ADDR_W),
                .ZERO_REG(ZERO_REG)
            ) u_rd (
                .ready   (ready),
                .re      (re[i]),
                .raddr   (ra),
                .we0     (we0),
                .waddr0  (waddr0),
                .wdata0  (wdata0),
                .we1     (we1),
                .waddr1  (waddr1),
                .wdata1  (wdata1),
                .reg_data(regs_q[ra]),
                .pend    (pend_q[ra]),
                .rdata   (rdata[i*DATA_W +: DATA_W]),
                .busy    (busy[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed stimulus pushes hand-computed expectations into a
// queue; a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int KR = 0;
    localparam int KB = 1;
    localparam int KI = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           init_done;
    logic           we0, we1, sb_set;
    logic [AW-1:0]  waddr0, waddr1, sb_addr;
    logic [DW-1:0]  wdata0, wdata1;
    logic [NR-1:0]  re;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]  busy;

    typedef struct {
        int            id;
        int            kind;
        int            port;
        logic [DW-1:0] exp;
    } chk_t;

    chk_t q[$];
    int compared   = 0;
    int mismatched = 0;
    int next_id    = 0;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata), .busy(busy),
        .sb_set(sb_set), .sb_addr(sb_addr)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input int kind, input int port, input logic [DW-1:0] exp);
        chk_t c;
        c.id = next_id; c.kind = kind; c.port = port; c.exp = exp;
        q.push_back(c);
        next_id++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; sb_set = 0; re = '0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; sb_addr = '0; raddr = '0;
    endtask

    task automatic rd(input int p, input int a, input logic en);
        logic [AW-1:0] av;
        av = AW'(a);
        raddr[p*AW +: AW] = av;
        re[p] = en;
    endtask

    task automatic wr(input int lane, input int a, input logic [DW-1:0] d);
        if (lane == 0) begin we0 = 1; waddr0 = AW'(a); wdata0 = d; end
        else begin we1 = 1; waddr1 = AW'(a); wdata1 = d; end
    endtask

    task automatic sweep_watch(input int n, input int rise_at);
        for (int k = 1; k <= n; k++) begin
            tick();
            expect_val(KI, 0, (k == rise_at) ? 1 : 0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                chk_t c;
                logic [DW-1:0] act;
                c = q.pop_front();
                act = (c.kind == KR) ? rdata[c.port*DW +: DW] :
                      (c.kind == KB) ? DW'(busy[c.port]) : DW'(init_done);
                compared++;
                if (act !== c.exp) begin
                    mismatched++;
                    $display("FAIL chk%0d kind=%0d port=%0d got %h want %h",
                             c.id, c.kind, c.port, act, c.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        rd(0, 5, 1); rd(1, 6, 1);
        expect_val(KI, 0, 0);
        expect_val(KB, 0, 1); expect_val(KB, 1, 1);
        expect_val(KR, 0, 0); expect_val(KR, 1, 0);
        rst = 0;
        // first sweep, with a write at cnt 5 to x3 that must be ignored
        for (int k = 1; k <= 32; k++) begin
            tick();
            idle();
            if (k == 5) begin
                wr(0, 3, 32'hFFFF); sb_set = 1; sb_addr = 4;
                rd(0, 3, 1); rd(1, 4, 1);
                expect_val(KB, 0, 1); expect_val(KB, 1, 1);
                expect_val(KR, 0, 0); expect_val(KR, 1, 0);
            end
            expect_val(KI, 0, (k == 32) ? 1 : 0);
        end
        for (int a = 0; a < 32; a += 2) begin
            tick();
            idle();
            rd(0, a, 1); rd(1, a + 1, 1);
            expect_val(KR, 0, 0); expect_val(KR, 1, 0);
            expect_val(KB, 0, 0); expect_val(KB, 1, 0);
        end
        // reset mid-sweep at cycle 10, then a full restart
        tick(); idle(); rst = 1;
        tick(); rst = 0; expect_val(KI, 0, 0);
        sweep_watch(10, 0);
        rst = 1;
        tick(); rst = 0; expect_val(KI, 0, 0);
        sweep_watch(32, 32);
        // dual write to the same address: lane 1 stored
        tick(); idle();
        wr(0, 7, 32'h1111); wr(1, 7, 32'h2222); rd(0, 7, 1);
        expect_val(KR, 0, 32'h2222); expect_val(KB, 0, 0);
        tick(); idle(); rd(0, 7, 1); rd(1, 7, 1);
        expect_val(KR, 0, 32'h2222); expect_val(KR, 1, 32'h2222);
        // distinct-address bypass on both lanes
        tick(); idle();
        wr(0, 3, 32'h3333); wr(1, 4, 32'h4444); rd(0, 3, 1); rd(1, 4, 1);
        expect_val(KR, 0, 32'h3333); expect_val(KR, 1, 32'h4444);
        tick(); idle(); rd(0, 3, 1); rd(1, 4, 1);
        expect_val(KR, 0, 32'h3333); expect_val(KR, 1, 32'h4444);
        // zero register
        tick(); idle();
        wr(0, 0, 32'hDEAD); sb_set = 1; sb_addr = 0; rd(0, 0, 1); rd(1, 7, 0);
        expect_val(KR, 0, 0); expect_val(KB, 0, 0);
        expect_val(KR, 1, 0); expect_val(KB, 1, 0);
        tick(); idle(); rd(0, 0, 1);
        expect_val(KR, 0, 0); expect_val(KB, 0, 0);
        // scoreboard set then clear by write
        tick(); idle(); sb_set = 1; sb_addr = 5; rd(0, 5, 1);
        expect_val(KB, 0, 0);
        tick(); idle(); rd(0, 5, 1); rd(1, 5, 0);
        expect_val(KB, 0, 1); expect_val(KB, 1, 1); expect_val(KR, 1, 0);
        tick(); idle(); wr(0, 5, 32'hABCD); rd(0, 5, 1);
        expect_val(KB, 0, 0); expect_val(KR, 0, 32'hABCD);
        tick(); idle(); rd(0, 5, 1);
        expect_val(KB, 0, 0); expect_val(KR, 0, 32'hABCD);
        // set/clear collision: set wins
        tick(); idle(); sb_set = 1; sb_addr = 9; wr(1, 9, 32'h99); rd(0, 9, 1);
        expect_val(KR, 0, 32'h99);
        tick(); idle(); rd(0, 9, 1); rd(1, 9, 1);
        expect_val(KB, 0, 1); expect_val(KB, 1, 1); expect_val(KR, 0, 32'h99);
        // lane 1 write clears the pending bit
        tick(); idle(); wr(1, 9, 32'h77); rd(0, 9, 1);
        expect_val(KB, 0, 0);
        tick(); idle(); rd(0, 9, 1);
        expect_val(KB, 0, 0); expect_val(KR, 0, 32'h77);
        // reset again: back to INIT outputs
        tick(); idle(); rst = 1; rd(0, 9, 1); rd(1, 7, 1);
        tick();
        expect_val(KI, 0, 0); expect_val(KB, 0, 1); expect_val(KB, 1, 1);
        expect_val(KR, 0, 0); expect_val(KR, 1, 0);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending checks want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
